// File: rtl/zxbus_pkg.sv
// Shared constants for the ZX bus port front end:
// port address match values and one-hot FSM encoding.
package zxbus_pkg;

   localparam logic [7:0] PORT_LO = 8'hAB;
   localparam logic [5:0] PORT_HI = 6'h20;
   localparam logic [1:0] NO_PORT = 2'b00;

   typedef logic [5:0] state_t;

   localparam int S_IDLE     = 0;
   localparam int S_WR_SETUP = 1;
   localparam int S_WR_STB   = 2;
   localparam int S_WR_REL   = 3;
   localparam int S_RD_DRIVE = 4;
   localparam int S_WAIT_END = 5;

   localparam state_t IDLE     = 6'b000001;
   localparam state_t WR_SETUP = 6'b000010;
   localparam state_t WR_STB   = 6'b000100;
   localparam state_t WR_REL   = 6'b001000;
   localparam state_t RD_DRIVE = 6'b010000;
   localparam state_t WAIT_END = 6'b100000;

endpackage

// File: rtl/zxbus_sync.sv
// Two-flop synchroniser for active-low bus strobes;
// resets to the inactive (high) level.
module zxbus_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s1;

   // Double-register the asynchronous inputs into clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '1;
         q  <= '1;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/zxbus_port_ctrl.sv
// Z80-side front end for ports #81AB/#82AB/#83AB:
// strobe sync, address decode, write strobe and read drive.
module zxbus_port_ctrl #(
   parameter logic [7:0] PORT_LO   = zxbus_pkg::PORT_LO,
   parameter logic [5:0] PORT_HI   = zxbus_pkg::PORT_HI,
   parameter int         WRSTB_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] za,
   input  logic [7:0]  zd_in,
   input  logic        ziorq_n,
   input  logic        zrd_n,
   input  logic        zwr_n,
   input  logic        zm1_n,
   output logic        wrstb_n,
   output logic        wrena,
   output logic [1:0]  addr,
   output logic [7:0]  wrdata,
   input  logic [7:0]  rddata,
   output logic [7:0]  zd_out,
   output logic        zd_oe,
   output logic        iorqge,
   output logic        busy
);

   import zxbus_pkg::*;

   logic [3:0] sync_q;
   logic       iorq_s;
   logic       rd_s;
   logic       wr_s;
   logic       m1_s;
   logic       io_rd;
   logic       io_wr;
   logic       hit;
   logic       stb_last;
   logic [2:0] cnt;
   state_t     state;
   state_t     nxt;

   zxbus_sync #(.W(4)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({zm1_n, zwr_n, zrd_n, ziorq_n}),
      .q     (sync_q)
   );

   assign iorq_s   = sync_q[0];
   assign rd_s     = sync_q[1];
   assign wr_s     = sync_q[2];
   assign m1_s     = sync_q[3];
   // M1 low with IORQ is an interrupt acknowledge, never a port access
   assign io_rd    = !iorq_s && !rd_s && m1_s;
   assign io_wr    = !iorq_s && !wr_s && m1_s;
   assign hit      = (za[7:0] == PORT_LO) && (za[15:10] == PORT_HI)
                  && (za[9:8] != NO_PORT);
   assign stb_last = (cnt == 3'(WRSTB_CYC - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next-state decode
   always_comb begin
      nxt = state;
      unique case (1'b1)
         state[S_IDLE]: begin
            if (io_rd && io_wr) nxt = WAIT_END;
            else if (io_wr)     nxt = hit ? WR_SETUP : WAIT_END;
            else if (io_rd)     nxt = hit ? RD_DRIVE : WAIT_END;
         end
         state[S_WR_SETUP]: nxt = WR_STB;
         state[S_WR_STB]:   if (stb_last) nxt = WR_REL;
         state[S_WR_REL]:   nxt = WAIT_END;
         state[S_RD_DRIVE]: if (!io_rd) nxt = IDLE;
         state[S_WAIT_END]: if (iorq_s && rd_s && wr_s) nxt = IDLE;
         default:           nxt = IDLE;
      endcase
   end

   // Strobe/enable outputs straight from one-hot state bits
   always_comb begin
      wrstb_n = !state[S_WR_STB];
      wrena   = state[S_WR_SETUP] | state[S_WR_STB] | state[S_WR_REL];
      zd_oe   = state[S_RD_DRIVE];
      busy    = !state[S_IDLE];
   end

   // Captured address/data, read data, claim flag and strobe counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr   <= NO_PORT;
         wrdata <= '0;
         zd_out <= '0;
         iorqge <= 1'b0;
         cnt    <= '0;
      end else begin
         if (state[S_IDLE] && (nxt[S_WR_SETUP] || nxt[S_RD_DRIVE])) begin
            addr   <= za[9:8];
            iorqge <= 1'b1;
         end
         if (state[S_IDLE] && nxt[S_WR_SETUP]) wrdata <= zd_in;
         if (state[S_WR_STB]) cnt <= cnt + 3'd1;
         else                 cnt <= '0;
         if (state[S_RD_DRIVE] && io_rd) zd_out <= rddata;
         if (!state[S_IDLE] && nxt[S_IDLE]) iorqge <= 1'b0;
      end
   end

endmodule
